change_dispense: RTL and testbench

CHANGE_DISPENSE -- requirements
Module: change_dispense

---
 rtl/change_dispense_if.sv | 33 +++
 rtl/change_dispense.sv | 162 ++++++++++++++++
 tb/tb_change_dispense.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispense_if.sv
// Request/status bundle for the change dispenser.
// With CHANGE_DISPENSE_ACK_EN the bundle also carries hopper_ack.
interface change_dispense_if;
    logic       start;
    logic [7:0] change_in;
    logic       coin10_out;
    logic       coin5_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] remaining;
`ifdef CHANGE_DISPENSE_ACK_EN
    logic       hopper_ack;

    modport master (
        output start, change_in, hopper_ack,
        input  coin10_out, coin5_out, busy, done, err, remaining
    );
    modport slave (
        input  start, change_in, hopper_ack,
        output coin10_out, coin5_out, busy, done, err, remaining
    );
`else
    modport master (
        output start, change_in,
        input  coin10_out, coin5_out, busy, done, err, remaining
    );
    modport slave (
        input  start, change_in,
        output coin10_out, coin5_out, busy, done, err, remaining
    );
`endif
endinterface

// File: rtl/change_dispense.sv
// Coin hopper driver: pays an amount out as 10-unit then 5-unit pulses.
// Optional CHANGE_DISPENSE_ACK_EN waits for hopper_ack after each coin.
module change_dispense #(
    parameter int PULSE_CYC = 100000,
    parameter int GAP_CYC   = 100000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    change_dispense_if.slave bus
);

    localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] G_LD = CW'(GAP_CYC - 1);

`ifdef CHANGE_DISPENSE_ACK_EN
    typedef enum logic [2:0] {
        IDLE, CHECK, PULSE, GAP, FINISH, WAIT_ACK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, CHECK, PULSE, GAP, FINISH
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rem_q, rem_d;
    logic          c10_q, c10_d;
    logic          c5_q, c5_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    state_t        pick_st;
    logic          pick_c10;
    logic          pick_c5;

    // Next coin choice from the amount left; shared by CHECK and GAP exit.
    always_comb begin
        pick_st  = FINISH;
        pick_c10 = 1'b0;
        pick_c5  = 1'b0;
        if (rem_q >= 8'd10) begin
            pick_st  = PULSE;
            pick_c10 = 1'b1;
        end else if (rem_q == 8'd5) begin
            pick_st  = PULSE;
            pick_c5  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        c10_d   = 1'b0;
        c5_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.change_in;
                    state_d = CHECK;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                if ((rem_q % 8'd5) != 8'd0) begin
                    err_d   = 1'b1;
                    rem_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = pick_st;
                    c10_d   = pick_c10;
                    c5_d    = pick_c5;
                    cnt_d   = (pick_st == PULSE) ? P_LD : '0;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    rem_d = c10_q ? rem_q - 8'd10 : rem_q - 8'd5;
`ifdef CHANGE_DISPENSE_ACK_EN
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
`else
                    state_d = GAP;
                    cnt_d   = G_LD;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    c10_d = c10_q;
                    c5_d  = c5_q;
                end
            end
`ifdef CHANGE_DISPENSE_ACK_EN
            WAIT_ACK: begin
                if (bus.hopper_ack) begin
                    state_d = GAP;
                    cnt_d   = G_LD;
                end
            end
`endif
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = pick_st;
                    c10_d   = pick_c10;
                    c5_d    = pick_c5;
                    cnt_d   = (pick_st == PULSE) ? P_LD : '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= 8'd0;
            c10_q   <= 1'b0;
            c5_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            c10_q   <= c10_d;
            c5_q    <= c5_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.coin10_out = c10_q;
    assign bus.coin5_out  = c5_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.remaining  = rem_q;

endmodule

// File: tb/tb_change_dispense.sv
// Randomised scoreboard bench for change_dispense (PULSE_CYC=4, GAP_CYC=3).
// Expected coin/done/err events are queued at start time and popped by a monitor.
module tb_change_dispense;

    localparam int P = 4;
    localparam int G = 3;
`ifdef CHANGE_DISPENSE_ACK_EN
    localparam int WAITC = 7;
`else
    localparam int WAITC = 0;
`endif

    typedef struct {
        int kind;
        int rem;
        int bsy;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    ev_t  q[$];

    change_dispense_if bus();

    change_dispense #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: kind 10/5 = coin, 1 = done, 2 = err
    task automatic model_push(input int a);
        int n;
        int f;
        if (a % 5 != 0) begin
            q.push_back('{2, 0, 1});
        end else begin
            n = a / 10;
            f = (a % 10 == 5) ? 1 : 0;
            for (int k = 0; k < n; k++) q.push_back('{10, a - 10 * k, 0});
            if (f == 1) q.push_back('{5, 5, 0});
            q.push_back('{1, 0, 2 + (n + f) * (P + G + WAITC)});
        end
    endtask

    task automatic do_req(input int a, input bit expect_accept);
        if (expect_accept) model_push(a);
        bus.start = 1'b1;
        bus.change_in = 8'(a);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.change_in = 8'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((q.size() != 0 || bus.busy) && n < limit);
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL timeout: pending=%0d busy=%0b", q.size(), bus.busy);
            q.delete();
        end
    endtask

    // Monitor
    int prev = 0, plen = 0, glen = 0, brun = 0;
    bit had = 0;

    function automatic bit get(output ev_t e);
        e = '{0, 0, 0};
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got output event expected none at %0t", $time);
            return 1'b0;
        end
        e = q.pop_front();
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        int  cur;
        ev_t e;
        if (!rst_n) begin
            prev = 0; plen = 0; glen = 0; brun = 0; had = 0;
        end else begin
            cur = bus.coin10_out ? 10 : (bus.coin5_out ? 5 : 0);
            if (bus.coin10_out && bus.coin5_out) chk("both_coins", 1, 0);
            if (bus.busy) brun++;
            if (cur != 0 && prev == 0) begin
                if (had) chk("gap_len", glen, G + WAITC);
                if (get(e)) begin
                    chk("coin_kind", cur, e.kind);
                    chk("coin_rem", int'(bus.remaining), e.rem);
                end
                plen = 1;
                had = 1;
            end else if (cur != 0) begin
                plen++;
            end else if (prev != 0) begin
                chk("pulse_len", plen, P);
                glen = 1;
            end else begin
                glen++;
            end
            if (bus.done || bus.err) begin
                if (bus.done && bus.err) chk("done_and_err", 1, 0);
                if (get(e)) begin
                    chk("end_kind", bus.done ? 1 : 2, e.kind);
                    chk("end_rem", int'(bus.remaining), 0);
                    chk("end_busy", int'(bus.busy), 0);
                    chk("busy_cycles", brun, e.bsy);
                    if (bus.done && had) chk("tail_gap", glen, G + WAITC + 2);
                end
                brun = 0;
                had = 0;
            end
            prev = cur;
        end
    end

`ifdef CHANGE_DISPENSE_ACK_EN
    initial begin
        bit pc = 0;
        bus.hopper_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (pc && !(bus.coin10_out || bus.coin5_out) && rst_n) begin
                repeat (6) @(negedge clk);
                #1;
                bus.hopper_ack = 1'b1;
                @(posedge clk);
                #1;
                bus.hopper_ack = 1'b0;
                pc = 0;
            end else begin
                pc = bus.coin10_out || bus.coin5_out;
            end
        end
    end
`endif

    initial begin
        int a;
        bus.start = 1'b0;
        bus.change_in = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_coin10", int'(bus.coin10_out), 0);
        chk("rst_coin5", int'(bus.coin5_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_rem", int'(bus.remaining), 0);

        // First start on the first edge after release
        rst_n = 1'b1;
        do_req(25, 1'b1);
        wait_idle(2000);
        do_req(0, 1'b1);
        wait_idle(2000);
        do_req(17, 1'b1);
        wait_idle(2000);
        do_req(255, 1'b1);
        wait_idle(2000);

        // Second request during the first pulse must be dropped
        do_req(10, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        do_req(50, 1'b0);
        wait_idle(2000);

        // Reset in the middle of the second coin10 pulse
        do_req(30, 1'b1);
        repeat (9 + WAITC) @(negedge clk);
        #1;
        chk("pre_rst_coin10", int'(bus.coin10_out), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_coin10", int'(bus.coin10_out), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_rem", int'(bus.remaining), 0);
        chk("arst_done", int'(bus.done), 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(5, 1'b1);
        wait_idle(2000);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) a = 5 * $urandom_range(0, 51);
            else a = $urandom_range(0, 255);
            do_req(a, 1'b1);
            wait_idle(2000);
        end

        repeat (3) @(negedge clk);
        chk("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
